// File: rtl/arbiter16_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : encoder16_4 / arbiter16_rr
// Purpose  : 16-way round-robin arbiter with a registered one-hot grant,
//            encoded grant index and optional maximum-tenure preemption.
// Revision : 1.0 - initial release
// ============================================================================

// One-hot (or zero) to binary index; zero input yields index 0.
module encoder16_4 (
    input  logic [15:0] onehot_i,
    output logic [3:0]  idx_o
);
    // OR together the indices of all set bits; exact for one-hot inputs
    always_comb begin
        idx_o = '0;
        for (int n = 0; n < 16; n++) begin
            if (onehot_i[n]) begin
                idx_o = idx_o | 4'(n);
            end
        end
    end
endmodule

module arbiter16_rr #(
    parameter int MAX_HOLD   = 16,
    parameter int HOLD_WIDTH = 5
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic [15:0] I_REQ,
    output logic [15:0] O_GRANT,
    output logic [3:0]  O_GRANT_IDX,
    output logic        O_GRANT_VALID,
    output logic        O_PREEMPT
);
    // With preemption disabled the tenure counter simply saturates at all-ones
    localparam logic [HOLD_WIDTH-1:0] HOLD_LIMIT =
        (MAX_HOLD == 0) ? {HOLD_WIDTH{1'b1}} : HOLD_WIDTH'(MAX_HOLD);
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE   = HOLD_WIDTH'(1);
    localparam bit                    PREEMPT_EN = (MAX_HOLD != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                  state_q,   state_d;
    logic [15:0]             grant_q,   grant_d;
    logic [3:0]              last_q,    last_d;
    logic [HOLD_WIDTH-1:0]   hold_q,    hold_d;
    logic                    preempt_q, preempt_d;

    logic [15:0] w_search_req;
    logic        w_owner_req;
    logic        w_found;
    logic [3:0]  w_winner;

    // While granting, the owner is excluded from the search so that a
    // preemption can never pick it again; on release its bit is 0 anyway.
    assign w_owner_req  = I_REQ[last_q];
    assign w_search_req = (state_q == ST_GRANT) ? (I_REQ & ~(16'd1 << last_q)) : I_REQ;

    // Rotating priority search: LAST+1, LAST+2, ... wrapping to LAST itself
    always_comb begin
        w_found  = 1'b0;
        w_winner = last_q;
        for (int i = 1; i <= 16; i++) begin
            if (!w_found && w_search_req[last_q + 4'(i)]) begin
                w_found  = 1'b1;
                w_winner = last_q + 4'(i);
            end
        end
    end

    // Next-state logic: idle acquisition, release handoff, preemption, hold
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    state_d = ST_GRANT;
                    grant_d = 16'd1 << w_winner;
                    last_d  = w_winner;
                    hold_d  = HOLD_ONE;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req) begin
                    if (w_found) begin
                        grant_d = 16'd1 << w_winner;
                        last_d  = w_winner;
                        hold_d  = HOLD_ONE;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        hold_d  = '0;
                    end
                end else if (PREEMPT_EN && (hold_q == HOLD_LIMIT) && w_found) begin
                    grant_d   = 16'd1 << w_winner;
                    last_d    = w_winner;
                    hold_d    = HOLD_ONE;
                    preempt_d = 1'b1;
                end else if (hold_q != HOLD_LIMIT) begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    // State registers; reset takes effect immediately, even mid-grant
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= 4'd15;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign O_GRANT       = grant_q;
    assign O_GRANT_VALID = |grant_q;
    assign O_PREEMPT     = preempt_q;

    encoder16_4 u_enc (
        .onehot_i (grant_q),
        .idx_o    (O_GRANT_IDX)
    );
endmodule
`default_nettype wire

// File: tb/tb_arbiter16_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_arbiter16_rr
// Purpose  : Directed-vector bench for arbiter16_rr (MAX_HOLD=4 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbiter16_rr;
    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] req0;
    logic [15:0] grant,  grant0;
    logic [3:0]  idx,    idx0;
    logic        valid,  valid0;
    logic        preempt, preempt0;

    int n_vec = 0;
    int n_err = 0;

    arbiter16_rr #(.MAX_HOLD(4), .HOLD_WIDTH(5)) u_dut (
        .I_CLK         (clk),
        .I_RESET       (rst),
        .I_REQ         (req),
        .O_GRANT       (grant),
        .O_GRANT_IDX   (idx),
        .O_GRANT_VALID (valid),
        .O_PREEMPT     (preempt)
    );

    arbiter16_rr #(.MAX_HOLD(0), .HOLD_WIDTH(3)) u_nop (
        .I_CLK         (clk),
        .I_RESET       (rst),
        .I_REQ         (req0),
        .O_GRANT       (grant0),
        .O_GRANT_IDX   (idx0),
        .O_GRANT_VALID (valid0),
        .O_PREEMPT     (preempt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] enc(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int n = 0; n < 16; n++) if (v[n]) r = 4'(n);
        return r;
    endfunction

    // Advance one edge, sample 1ns later and check the invariants
    task automatic step();
        @(posedge clk);
        #1;
        check_eq("inv_onehot",  32'($onehot0(grant)), 32'd1);
        check_eq("inv_valid",   32'(valid), 32'(|grant));
        check_eq("inv_idx",     32'(idx), 32'(enc(grant)));
        check_eq("inv_preempt", 32'(preempt & ~valid), 32'd0);
    endtask

    logic [3:0] rot_exp [5];

    initial begin
        rot_exp[0] = 4'd2; rot_exp[1] = 4'd5; rot_exp[2] = 4'd9;
        rot_exp[3] = 4'd2; rot_exp[4] = 4'd5;

        rst  = 1'b1;
        req  = 16'h0000;
        req0 = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_grant",   32'(grant),   32'h0);
        check_eq("rst_valid",   32'(valid),   32'h0);
        check_eq("rst_idx",     32'(idx),     32'h0);
        check_eq("rst_preempt", 32'(preempt), 32'h0);
        check_eq("rst_grant0",  32'(grant0),  32'h0);
        rst = 1'b0;

        // 1: asynchronous reset mid-grant
        req = 16'h0008;
        step();
        check_eq("t1_grant", 32'(grant), 32'h0008);
        check_eq("t1_idx",   32'(idx),   32'd3);
        rst = 1'b1;
        #2;
        check_eq("t1_async_grant", 32'(grant), 32'h0);
        check_eq("t1_async_valid", 32'(valid), 32'h0);
        #1;
        rst = 1'b0;
        req = 16'h8001;
        step();
        check_eq("t1_after_grant", 32'(grant), 32'h0001);
        check_eq("t1_after_idx",   32'(idx),   32'd0);
        req = 16'h0000;
        step();
        check_eq("t1_idle", 32'(grant), 32'h0);

        // 2: rotation among 2,5,9 with owners dropping after one cycle
        req = 16'h0224;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("t2_rot_idx",   32'(idx),   32'(rot_exp[k]));
            check_eq("t2_rot_valid", 32'(valid), 32'd1);
            req = 16'h0224 & ~(16'd1 << idx);
        end
        req = 16'h0000;
        step();
        check_eq("t2_idle", 32'(grant), 32'h0);

        // 3: wrap-around handoff from owner 15
        req = 16'h8000;
        step();
        check_eq("t3_own15", 32'(grant), 32'h8000);
        req = 16'hC001;
        step();
        check_eq("t3_hold15", 32'(grant), 32'h8000);
        req = 16'h4001;
        step();
        check_eq("t3_wrap_grant", 32'(grant), 32'h0001);
        check_eq("t3_wrap_idx",   32'(idx),   32'd0);
        check_eq("t3_wrap_valid", 32'(valid), 32'd1);
        req = 16'h4000;
        step();
        check_eq("t3_next_idx", 32'(idx), 32'd14);
        req = 16'h0000;
        step();
        check_eq("t3_idle", 32'(grant), 32'h0);

        // 4: preemption after exactly 4 grant cycles
        req = 16'h0008;
        step();
        check_eq("t4_c1", 32'(grant), 32'h0008);
        step();
        check_eq("t4_c2", 32'(grant), 32'h0008);
        req = 16'h0088;
        step();
        check_eq("t4_c3", 32'(grant), 32'h0008);
        step();
        check_eq("t4_c4",         32'(grant),   32'h0008);
        check_eq("t4_c4_preempt", 32'(preempt), 32'd0);
        step();
        check_eq("t4_pre_grant",   32'(grant),   32'h0080);
        check_eq("t4_pre_idx",     32'(idx),     32'd7);
        check_eq("t4_pre_preempt", 32'(preempt), 32'd1);
        step();
        check_eq("t4_post_grant",   32'(grant),   32'h0080);
        check_eq("t4_post_preempt", 32'(preempt), 32'd0);
        req = 16'h0008;
        step();
        check_eq("t4_regrant",         32'(grant),   32'h0008);
        check_eq("t4_regrant_preempt", 32'(preempt), 32'd0);
        req = 16'h0000;
        step();
        check_eq("t4_idle", 32'(grant), 32'h0);

        // 5: lone requester is never preempted
        req = 16'h0400;
        for (int k = 0; k < 20; k++) begin
            step();
            check_eq("t5_grant",   32'(grant),   32'h0400);
            check_eq("t5_preempt", 32'(preempt), 32'd0);
        end
        req = 16'h0000;
        step();
        check_eq("t5_idle", 32'(grant), 32'h0);

        // 6: MAX_HOLD=0 instance, requester 0 holds indefinitely
        req0 = 16'h0003;
        for (int k = 0; k < 40; k++) begin
            step();
            check_eq("t6_grant",   32'(grant0),   32'h0001);
            check_eq("t6_idx",     32'(idx0),     32'd0);
            check_eq("t6_preempt", 32'(preempt0), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/arbiter16_rr.md
Name: arbiter16_rr

Overview:
- Round-robin arbiter that shares one resource among up to 16 requesters, e.g. a memory port or the register-file write port between datapath and I/O masters.
- Produces a registered one-hot grant and its 4-bit encoded index; the index comes from an instance of encoder16_4.
- Enforces fairness with a rotating priority pointer and an optional maximum-tenure preemption counter.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles before preemption when other requesters are waiting; 0 disables preemption.
- HOLD_WIDTH, 5, width of the tenure counter; must hold MAX_HOLD.

Ports:
- I_CLK  input  1  system clock; all state updates on the rising edge.
- I_RESET  input  1  asynchronous, active-high reset.
- I_REQ  input  16  request lines; bit n is requester n, level-sensitive, held high for the whole transaction.
- O_GRANT  output  16  registered grant; zero or one-hot.
- O_GRANT_IDX  output  4  encoder16_4(O_GRANT); 0 when no grant.
- O_GRANT_VALID  output  1  high when O_GRANT is nonzero.
- O_PREEMPT  output  1  one-cycle pulse, high in the first cycle of a grant created by preemption.

Behaviour:
- Reset is asynchronous and immediate, mid-transaction included:
  - O_GRANT=0, O_GRANT_VALID=0, O_PREEMPT=0, O_GRANT_IDX=0.
  - State=IDLE, LAST=15, HOLD_CNT=0.
- LAST is the index of the most recent winner. The search order is LAST+1, LAST+2, … mod 16, ending at LAST itself. LAST=15 at reset, so requester 0 has top priority first.
- Latency: a request sampled at edge k is granted at edge k (grant visible in cycle k+1). There is no combinational path from I_REQ to the outputs.
- State IDLE:
  - I_REQ==0: stay IDLE.
  - Otherwise: grant the winner, LAST<=winner, HOLD_CNT<=1, go to GRANT, O_PREEMPT<=0.
- State GRANT (owner o = LAST), evaluated at each edge:
  - Release, when I_REQ[o]==0:
    - If I_REQ!=0, hand off directly to the winner (search from o+1). There is no idle cycle, HOLD_CNT<=1 and O_PREEMPT<=0.
    - If I_REQ==0, go to IDLE and clear the grant.
  - Preempt, when I_REQ[o]==1, MAX_HOLD!=0, HOLD_CNT==MAX_HOLD, and (I_REQ & ~(1<<o))!=0:
    - Grant the winner among the other requesters (search o+1 … o-1).
    - LAST<=winner, HOLD_CNT<=1, O_PREEMPT<=1.
  - Hold, otherwise:
    - The grant is unchanged and O_PREEMPT<=0.
    - HOLD_CNT increments, saturating at MAX_HOLD (saturating at 2^HOLD_WIDTH-1 when MAX_HOLD=0).
- A lone requester at MAX_HOLD is never preempted; it holds indefinitely with HOLD_CNT saturated.
- A preempted requester that keeps I_REQ high re-enters the rotation normally. It is not favoured.
- Requests that arrive in the same cycle as a release or preempt take part in that cycle's search.
- Invariants, checked every cycle:
  - O_GRANT is zero or one-hot.
  - O_GRANT_VALID == |O_GRANT.
  - O_GRANT_IDX == encoder16_4(O_GRANT).
  - O_PREEMPT implies O_GRANT_VALID.
- HOLD_CNT is internal: the number of consecutive cycles the current grant has been valid, counting from 1.

Test Plan:
1. Async reset: hold I_REQ=16'h0008 until grant 0x0008, then pulse I_RESET between edges -> O_GRANT=0, O_GRANT_VALID=0 before the next edge. After release, I_REQ=16'h8001 -> O_GRANT=0x0001, O_GRANT_IDX=0.
2. Rotation: I_REQ=16'h0224; the bench drops each owner's bit one cycle after its grant and re-raises it one cycle later -> grant sequence idx 2,5,9,2,5 with no idle cycles between grants.
3. Wrap-around handoff: owner 15, I_REQ=16'hC001, then bit 15 drops -> next grant 0x0001, idx 0, same edge (O_GRANT_VALID stays 1). Then owner 0 drops with bit 14 still set -> grant idx 14.
4. Preemption, MAX_HOLD=4: I_REQ[3] held continuously, I_REQ[7] raised in grant cycle 2 -> idx 3 granted exactly 4 cycles, then 0x0080, idx 7, O_PREEMPT=1 for one cycle. With I_REQ[3] still high after 7 drops, 3 is re-granted.
5. No-contender hold: MAX_HOLD=4, only I_REQ[10] high for 20 cycles -> grant 0x0400 constant and O_PREEMPT never asserted.
6. MAX_HOLD=0: I_REQ=16'h0003 held 40 cycles -> requester 0 holds throughout and requester 1 is never granted, with no preemption.
